// File: rtl/render_pkg.sv
// -----------------------------------------------------------------------------
// render_pkg
// Shared constants and types for the triangle fetch path.
//   ADDR_W      face / vertex SRAM address width
//   COORD_W     width of one vertex coordinate
//   COLOR_W     width of one vertex color
//   FACE_CNT_W  width of the face count and face counter
//   SRAM_LAT    cycles from a registered address to sample-able read data
//   state_t     fetch scheduler states
//   vertex_t    one vertex {x, y, z, color}
//   triangle_t  three vertices (v[0] is v1) plus the last-face flag
// -----------------------------------------------------------------------------
package render_pkg;

    localparam int ADDR_W     = 20;
    localparam int COORD_W    = 24;
    localparam int COLOR_W    = 24;
    localparam int FACE_CNT_W = 21;
    localparam int SRAM_LAT   = 3;

    typedef enum logic [2:0] {
        IDLE,
        FACE_REQ,
        FACE_WAIT,
        VERT_REQ,
        VERT_WAIT,
        PUSH,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COLOR_W-1:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t [2:0] v;
        logic          last;
    } triangle_t;

    localparam int TRI_W = $bits(triangle_t);

endpackage

// File: rtl/tri_fifo.sv
// -----------------------------------------------------------------------------
// tri_fifo
// DEPTH-entry first-word-fall-through buffer of packed triangle_t words.
//   clk, srst_n   clock, synchronous active-low reset
//   push_i/din_i  write a word (accepted when not full, or full with a pop)
//   pop_i         remove the head (ignored when empty)
//   dout_o        head word; forced to 0 while empty
//   full_o        occupancy == DEPTH
//   empty_o       occupancy == 0
//   count_o       current occupancy
// -----------------------------------------------------------------------------
module tri_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic                       push_i,
    input  logic [TRI_W-1:0]           din_i,
    input  logic                       pop_i,
    output logic [TRI_W-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TRI_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push_i && (!full_o || do_pop);
    // Masking by empty keeps reset-time outputs at zero without resetting storage.
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // NOTE: the storage array has no reset; only pointers and count are reset,
    // and the empty mask above stops stale words from ever reaching the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/triangle_fetch_unit.sv
// -----------------------------------------------------------------------------
// triangle_fetch_unit
// Fetches faces 0..num_of_faces-1: one face SRAM read, then three back-to-back
// vertex SRAM reads, assembling one triangle into a FWFT buffer per face.
//   clk, srst_n          clock, synchronous active-low reset
//   start, num_of_faces  begin a run (sampled in IDLE); count latched on start
//   face_addr            registered face SRAM address
//   face_v1..face_v3     vertex indices returned by the face SRAM
//   vert_addr            registered vertex SRAM address
//   vert_x/y/z/color     vertex SRAM data
//   tri_valid/tri_ready  head-of-buffer handshake
//   tri_x/y/z/color      head triangle, v1 in the LSBs
//   tri_last             head triangle is the final face
//   busy, done           run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module triangle_fetch_unit
    import render_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    start,
    input  logic [FACE_CNT_W-1:0]   num_of_faces,
    output logic [ADDR_W-1:0]       face_addr,
    input  logic [ADDR_W-1:0]       face_v1,
    input  logic [ADDR_W-1:0]       face_v2,
    input  logic [ADDR_W-1:0]       face_v3,
    output logic [ADDR_W-1:0]       vert_addr,
    input  logic [COORD_W-1:0]      vert_x,
    input  logic [COORD_W-1:0]      vert_y,
    input  logic [COORD_W-1:0]      vert_z,
    input  logic [COLOR_W-1:0]      vert_color,
    output logic                    tri_valid,
    input  logic                    tri_ready,
    output logic [3*COORD_W-1:0]    tri_x,
    output logic [3*COORD_W-1:0]    tri_y,
    output logic [3*COORD_W-1:0]    tri_z,
    output logic [3*COLOR_W-1:0]    tri_color,
    output logic                    tri_last,
    output logic                    busy,
    output logic                    done
);

    localparam int WAIT_W = $clog2(SRAM_LAT + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    state_t                   state_q, state_d;
    logic [FACE_CNT_W-1:0]    count_q, fc_q;
    logic [WAIT_W-1:0]        wait_q;
    logic [1:0]               vidx_q;
    logic [ADDR_W-1:0]        v1_q, v2_q, v3_q;
    logic [ADDR_W-1:0]        face_addr_q, vert_addr_q, vsel;
    // One-hot slot tag per outstanding vertex read; the oldest stage lines up
    // with the cycle its data is on vert_*.
    logic [SRAM_LAT-1:0][2:0] tag_q;
    logic [2:0]               tag_in;
    triangle_t                tri_q, push_tri, head_tri;
    logic                     busy_q, done_q;
    logic                     accept, face_issue, face_capture, vert_issue, push, pop;
    logic                     fifo_full, fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [TRI_W-1:0]         fifo_dout;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!srst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = (num_of_faces == '0) ? DONE : FACE_REQ;
            FACE_REQ:  if (!fifo_full) state_d = FACE_WAIT;
            FACE_WAIT: if (wait_q == '0) state_d = VERT_REQ;
            VERT_REQ:  if (vidx_q == 2'd2) state_d = VERT_WAIT;
            VERT_WAIT: if (tag_q[SRAM_LAT-1][2]) state_d = PUSH;
            PUSH:      state_d = ((fc_q + FACE_CNT_W'(1)) < count_q) ? FACE_REQ : DRAIN;
            DRAIN:     if (fifo_count == '0) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath enables ----------------
    always_comb begin
        accept       = (state_q == IDLE) && start;
        // Admitting a face only with a free slot guarantees its push later.
        face_issue   = (state_q == FACE_REQ) && !fifo_full;
        face_capture = (state_q == FACE_WAIT) && (wait_q == '0);
        vert_issue   = (state_q == VERT_REQ);
        push         = (state_q == PUSH);
        tag_in       = vert_issue ? (3'b001 << vidx_q) : 3'b000;
        case (vidx_q)
            2'd0:    vsel = v1_q;
            2'd1:    vsel = v2_q;
            default: vsel = v3_q;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            count_q     <= '0;
            fc_q        <= '0;
            wait_q      <= '0;
            vidx_q      <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            v3_q        <= '0;
            face_addr_q <= '0;
            vert_addr_q <= '0;
            tag_q       <= '0;
            tri_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                count_q <= num_of_faces;
                fc_q    <= '0;
                busy_q  <= 1'b1;
            end
            if (face_issue) begin
                face_addr_q <= fc_q[ADDR_W-1:0];
                wait_q      <= WAIT_W'(SRAM_LAT - 1);
            end else if ((state_q == FACE_WAIT) && (wait_q != '0)) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            if (face_capture) begin
                v1_q   <= face_v1;
                v2_q   <= face_v2;
                v3_q   <= face_v3;
                vidx_q <= '0;
            end
            if (vert_issue) begin
                vert_addr_q <= vsel;
                vidx_q      <= vidx_q + 2'd1;
            end
            tag_q[0] <= tag_in;
            for (int i = 1; i < SRAM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            for (int s = 0; s < 3; s++) begin
                if (tag_q[SRAM_LAT-1][s]) tri_q.v[s] <= {vert_x, vert_y, vert_z, vert_color};
            end
            if (push) fc_q <= fc_q + FACE_CNT_W'(1);
            done_q <= (state_q == DONE);
            if (state_q == DONE) busy_q <= 1'b0;
        end
    end

    always_comb begin
        push_tri      = tri_q;
        push_tri.last = (fc_q == (count_q - FACE_CNT_W'(1)));
    end

    tri_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .srst_n  (srst_n),
        .push_i  (push),
        .din_i   (push_tri),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_tri  = fifo_dout;
    assign tri_valid = !fifo_empty;
    assign pop       = tri_valid && tri_ready;
    assign tri_x     = {head_tri.v[2].x,     head_tri.v[1].x,     head_tri.v[0].x};
    assign tri_y     = {head_tri.v[2].y,     head_tri.v[1].y,     head_tri.v[0].y};
    assign tri_z     = {head_tri.v[2].z,     head_tri.v[1].z,     head_tri.v[0].z};
    assign tri_color = {head_tri.v[2].color, head_tri.v[1].color, head_tri.v[0].color};
    assign tri_last  = head_tri.last;
    assign face_addr = face_addr_q;
    assign vert_addr = vert_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_triangle_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_triangle_fetch_unit
// Scoreboard bench: stimulus pushes expected triangles into a queue, a negedge
// monitor compares the head whenever tri_valid is high and pops on accept.
// Face and vertex SRAMs are modelled as address functions behind SRAM_LAT.
// -----------------------------------------------------------------------------
module tb_triangle_fetch_unit;
    import render_pkg::*;

    logic                  clk = 1'b0;
    logic                  srst_n;
    logic                  start;
    logic [FACE_CNT_W-1:0] num_of_faces;
    logic [ADDR_W-1:0]     face_addr, vert_addr;
    logic [ADDR_W-1:0]     face_v1, face_v2, face_v3;
    logic [COORD_W-1:0]    vert_x, vert_y, vert_z;
    logic [COLOR_W-1:0]    vert_color;
    logic                  tri_valid, tri_ready, tri_last, busy, done;
    logic [3*COORD_W-1:0]  tri_x, tri_y, tri_z;
    logic [3*COLOR_W-1:0]  tri_color;

    always #5 clk = ~clk;

    triangle_fetch_unit #(.DEPTH(2)) dut (
        .clk(clk), .srst_n(srst_n), .start(start), .num_of_faces(num_of_faces),
        .face_addr(face_addr), .face_v1(face_v1), .face_v2(face_v2), .face_v3(face_v3),
        .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y), .vert_z(vert_z),
        .vert_color(vert_color), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x(tri_x), .tri_y(tri_y), .tri_z(tri_z), .tri_color(tri_color),
        .tri_last(tri_last), .busy(busy), .done(done)
    );

    // ---------------- memory contents ----------------
    function automatic logic [ADDR_W-1:0] fv(input logic [ADDR_W-1:0] fa, input int k);
        if (fa == '0) return (k == 0) ? ADDR_W'(5) : (k == 1) ? ADDR_W'(9) : ADDR_W'(2);
        return (fa << 2) + ADDR_W'(16 + k);
    endfunction

    function automatic logic [95:0] vmem(input logic [ADDR_W-1:0] a);
        return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
    endfunction

    // ---------------- SRAM latency models ----------------
    logic [3*ADDR_W-1:0] f_rd0, f_data;
    logic [3*ADDR_W-1:0] f_pipe [SRAM_LAT];
    logic [95:0]         v_rd0, v_data;
    logic [95:0]         v_pipe [SRAM_LAT];

    always_comb f_rd0 = {fv(face_addr, 2), fv(face_addr, 1), fv(face_addr, 0)};
    always_comb v_rd0 = vmem(vert_addr);

    always @(posedge clk) begin
        f_pipe[0] <= f_rd0;
        v_pipe[0] <= v_rd0;
        for (int i = 1; i < SRAM_LAT; i++) begin
            f_pipe[i] <= f_pipe[i-1];
            v_pipe[i] <= v_pipe[i-1];
        end
    end

    assign f_data = (SRAM_LAT == 1) ? f_rd0 : f_pipe[(SRAM_LAT > 1) ? SRAM_LAT-2 : 0];
    assign v_data = (SRAM_LAT == 1) ? v_rd0 : v_pipe[(SRAM_LAT > 1) ? SRAM_LAT-2 : 0];
    assign {face_v3, face_v2, face_v1}         = f_data;
    assign {vert_x, vert_y, vert_z, vert_color} = v_data;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3*COORD_W-1:0] x, y, z;
        logic [3*COLOR_W-1:0] c;
        logic                 last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_delivered = 0;
    int   n_done = 0;
    logic busy_prev = 1'b0;

    function automatic exp_t mk_exp(input int f, input logic last);
        exp_t e;
        logic [95:0] a, b, c;
        a = vmem(fv(ADDR_W'(f), 0));
        b = vmem(fv(ADDR_W'(f), 1));
        c = vmem(fv(ADDR_W'(f), 2));
        e.x    = {c[95:72], b[95:72], a[95:72]};
        e.y    = {c[71:48], b[71:48], a[71:48]};
        e.z    = {c[47:24], b[47:24], a[47:24]};
        e.c    = {c[23:0],  b[23:0],  a[23:0]};
        e.last = last;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!srst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (tri_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tri: got tri_x=%0h, required no triangle", tri_x);
                end else begin
                    mon_e = sb_q[0];
                    check("tri_x",     128'(tri_x),     128'(mon_e.x));
                    check("tri_y",     128'(tri_y),     128'(mon_e.y));
                    check("tri_z",     128'(tri_z),     128'(mon_e.z));
                    check("tri_color", 128'(tri_color), 128'(mon_e.c));
                    check("tri_last",  128'(tri_last),  128'(mon_e.last));
                    if (tri_ready) begin
                        void'(sb_q.pop_front());
                        n_delivered++;
                    end
                end
            end
            if (busy_prev && !busy) check("busy_fall_with_done", 128'(done), 128'(1));
            if (done) n_done++;
            busy_prev = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        for (int f = 0; f < n; f++) sb_q.push_back(mk_exp(f, f == n - 1));
        num_of_faces = FACE_CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_within_budget", 128'(seen), 128'(1));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic found;

        srst_n = 1'b0; start = 1'b0; num_of_faces = '0; tri_ready = 1'b0;
        repeat (3) tick();
        check("rst_face_addr", 128'(face_addr), 128'(0));
        check("rst_vert_addr", 128'(vert_addr), 128'(0));
        check("rst_tri_valid", 128'(tri_valid), 128'(0));
        check("rst_tri_x",     128'(tri_x),     128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_done",      128'(done),      128'(0));
        srst_n = 1'b1;
        tick();

        // ---- zero faces ----
        tri_ready = 1'b1;
        do_start(0);
        check("zero_busy_set", 128'(busy), 128'(1));
        check("zero_done_early", 128'(done), 128'(0));
        tick();
        check("zero_done_pulse", 128'(done), 128'(1));
        check("zero_busy_clear", 128'(busy), 128'(0));
        check("zero_face_addr", 128'(face_addr), 128'(0));
        tick();
        check("zero_done_one_cycle", 128'(done), 128'(0));
        check("zero_no_tri", 128'(tri_valid), 128'(0));

        // ---- single face, exact latency ----
        base = n_done;
        do_start(1);
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 1)  check("t1_face_addr", 128'(face_addr), 128'(0));
            if (i == 4)  check("t1_vaddr_hold", 128'(vert_addr), 128'(0));
            if (i == 5)  check("t1_vaddr_v1", 128'(vert_addr), 128'(5));
            if (i == 6)  check("t1_vaddr_v2", 128'(vert_addr), 128'(9));
            if (i == 7)  check("t1_vaddr_v3", 128'(vert_addr), 128'(2));
            if (i == 10) check("t1_valid_early", 128'(tri_valid), 128'(0));
            if (i == 11) begin
                check("t1_valid_at_11", 128'(tri_valid), 128'(1));
                check("t1_x_literal", 128'(tri_x), 128'({24'h100002, 24'h100009, 24'h100005}));
                check("t1_color_literal", 128'(tri_color), 128'({24'h400002, 24'h400009, 24'h400005}));
                check("t1_last", 128'(tri_last), 128'(1));
            end
        end
        wait_done(20);
        check("t1_done_count", 128'(n_done - base), 128'(1));
        check("t1_sb_empty", 128'(sb_q.size()), 128'(0));

        // ---- back-pressure: 4 faces with consumer stalled ----
        tri_ready = 1'b0;
        do_start(4);
        repeat (60) tick();
        check("bp_valid", 128'(tri_valid), 128'(1));
        check("bp_face_addr_held", 128'(face_addr), 128'(1));
        check("bp_busy", 128'(busy), 128'(1));
        check("bp_none_popped", 128'(sb_q.size()), 128'(4));
        tri_ready = 1'b1;
        wait_done(200);
        check("bp_sb_empty", 128'(sb_q.size()), 128'(0));

        // ---- start while busy and num_of_faces change are ignored ----
        base = n_delivered;
        do_start(3);
        repeat (5) tick();
        num_of_faces = FACE_CNT_W'(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        repeat (40) tick();
        check("ign_delivered", 128'(n_delivered - base), 128'(3));
        check("ign_no_restart", 128'(busy), 128'(0));
        check("ign_sb_empty", 128'(sb_q.size()), 128'(0));

        // ---- random back-pressure over 50 faces ----
        base = n_delivered;
        do_start(50);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tri_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("rnd_done", 128'(found), 128'(1));
        tri_ready = 1'b1;
        tick();
        check("rnd_delivered", 128'(n_delivered - base), 128'(50));
        check("rnd_sb_empty", 128'(sb_q.size()), 128'(0));

        // ---- reset during VERT_REQ of face 2 ----
        do_start(4);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (face_addr == ADDR_W'(2)) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_face2", 128'(found), 128'(1));
        repeat (SRAM_LAT + 1) tick();
        check("rst_in_vert_req", 128'(vert_addr), 128'(fv(ADDR_W'(2), 0)));
        srst_n = 1'b0;
        tick();
        check("mid_rst_face_addr", 128'(face_addr), 128'(0));
        check("mid_rst_vert_addr", 128'(vert_addr), 128'(0));
        check("mid_rst_tri_valid", 128'(tri_valid), 128'(0));
        check("mid_rst_tri_last",  128'(tri_last),  128'(0));
        check("mid_rst_tri_bus",   128'({tri_x, tri_z}), 128'(0));
        check("mid_rst_busy",      128'(busy),      128'(0));
        check("mid_rst_done",      128'(done),      128'(0));
        srst_n = 1'b1;
        sb_q.delete();
        base = n_delivered;
        repeat (40) tick();
        check("post_rst_no_tri", 128'(n_delivered - base), 128'(0));
        check("post_rst_idle", 128'(busy), 128'(0));
        do_start(2);
        wait_done(200);
        check("restart_delivered", 128'(n_delivered - base), 128'(2));
        check("restart_sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
